// File: rtl/igu_pipe.sv
// Immediate generation with a two-entry (main + skid) elastic buffer and 1-cycle latency.
// Define YSYX_23060251_IGU_TGT_EN to enable the pc + imm target adder; otherwise tgt_o is 0.
module igu_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [5:0]      imm_sel_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] tgt_o,
    output logic            sel_err_o
);

    logic [31:0]     raw;
    logic [XLEN-1:0] imm_n, tgt_n;
    logic            err_n;

    always_comb begin
        raw   = '0;
        err_n = |(imm_sel_i & (imm_sel_i - 6'd1));
        case (imm_sel_i)
            6'b000001: raw = {{20{inst_i[31]}}, inst_i[31:20]};
            6'b000010: raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            6'b000100: raw = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            6'b001000: raw = {inst_i[31:12], 12'b0};
            6'b010000: raw = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            6'b100000: raw = {27'b0, inst_i[19:15]};
            default:   raw = '0;
        endcase
    end

    // Every format is produced as a signed 32-bit value; widen once for RV64.
    generate
        if (XLEN > 32) begin : g_sext
            assign imm_n = {{(XLEN-32){raw[31]}}, raw};
        end else begin : g_nosext
            assign imm_n = raw[XLEN-1:0];
        end
    endgenerate

`ifdef YSYX_23060251_IGU_TGT_EN
    assign tgt_n = pc_i + imm_n;
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign tgt_n     = '0;
`endif

    logic            m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q, rdy_d;
    logic [XLEN-1:0] m_imm_q, m_imm_d, m_tgt_q, m_tgt_d;
    logic [XLEN-1:0] s_imm_q, s_imm_d, s_tgt_q, s_tgt_d;
    logic            m_err_q, m_err_d, s_err_q, s_err_d;
    logic            acc, drn;

    assign acc = in_valid_i & in_ready_o;
    assign drn = m_vld_q & out_ready_i;

    always_comb begin
        m_vld_d = m_vld_q;
        m_imm_d = m_imm_q;
        m_tgt_d = m_tgt_q;
        m_err_d = m_err_q;
        s_vld_d = s_vld_q;
        s_imm_d = s_imm_q;
        s_tgt_d = s_tgt_q;
        s_err_d = s_err_q;
        if (flush_i) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q || drn) begin
            // Skid is only ever full while main is held, so it refills main first.
            if (s_vld_q) begin
                m_vld_d = 1'b1;
                m_imm_d = s_imm_q;
                m_tgt_d = s_tgt_q;
                m_err_d = s_err_q;
                s_vld_d = 1'b0;
            end else if (acc) begin
                m_vld_d = 1'b1;
                m_imm_d = imm_n;
                m_tgt_d = tgt_n;
                m_err_d = err_n;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (acc) begin
            s_vld_d = 1'b1;
            s_imm_d = imm_n;
            s_tgt_d = tgt_n;
            s_err_d = err_n;
        end
        rdy_d = !s_vld_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_vld_q <= 1'b0;
            m_imm_q <= '0;
            m_tgt_q <= '0;
            m_err_q <= 1'b0;
            s_vld_q <= 1'b0;
            s_imm_q <= '0;
            s_tgt_q <= '0;
            s_err_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            m_vld_q <= m_vld_d;
            m_imm_q <= m_imm_d;
            m_tgt_q <= m_tgt_d;
            m_err_q <= m_err_d;
            s_vld_q <= s_vld_d;
            s_imm_q <= s_imm_d;
            s_tgt_q <= s_tgt_d;
            s_err_q <= s_err_d;
            rdy_q   <= rdy_d;
        end
    end

    // Held low while reset is asserted so nothing is offered during reset.
    assign in_ready_o  = rdy_q & ~rst_i;
    assign out_valid_o = m_vld_q;
    assign imm_o       = m_imm_q;
    assign tgt_o       = m_tgt_q;
    assign sel_err_o   = m_err_q;

endmodule

// File: tb/tb_igu_pipe.sv
// Directed bench for igu_pipe: XLEN=64 and XLEN=32 instances share one stimulus stream.
module tb_igu_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [5:0]  sel;
    logic [31:0] inst;
    logic [63:0] pc;

    logic        rdy64, vld64, err64, rdy32, vld32, err32;
    logic [63:0] imm64, tgt64;
    logic [31:0] imm32, tgt32;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    igu_pipe #(.XLEN(64)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy64),
        .imm_sel_i(sel), .inst_i(inst), .pc_i(pc),
        .out_valid_o(vld64), .out_ready_i(out_ready),
        .imm_o(imm64), .tgt_o(tgt64), .sel_err_o(err64)
    );

    igu_pipe #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy32),
        .imm_sel_i(sel), .inst_i(inst), .pc_i(pc[31:0]),
        .out_valid_o(vld32), .out_ready_i(out_ready),
        .imm_o(imm32), .tgt_o(tgt32), .sel_err_o(err32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] tgt_exp64(input logic [63:0] p, input logic [63:0] i);
`ifdef YSYX_23060251_IGU_TGT_EN
        return p + i;
`else
        return 64'd0 & (p ^ i);
`endif
    endfunction

    function automatic logic [63:0] tgt_exp32(input logic [63:0] p, input logic [63:0] i);
`ifdef YSYX_23060251_IGU_TGT_EN
        logic [31:0] s;
        s = p[31:0] + i[31:0];
        return {32'd0, s};
`else
        return 64'd0 & (p ^ i);
`endif
    endfunction

    // Present one entry with out_ready high; it must appear on the very next cycle.
    task automatic vec(input string tag, input logic [5:0] s, input logic [31:0] ins,
                       input logic [63:0] p, input logic [63:0] e64, input logic [31:0] e32,
                       input logic eerr);
        sel = s; inst = ins; pc = p; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk({tag, ".vld"}, {63'd0, vld64}, 64'd1);
        chk({tag, ".imm64"}, imm64, e64);
        chk({tag, ".tgt64"}, tgt64, tgt_exp64(p, e64));
        chk({tag, ".err64"}, {63'd0, err64}, {63'd0, eerr});
        chk({tag, ".imm32"}, {32'd0, imm32}, {32'd0, e32});
        chk({tag, ".tgt32"}, {32'd0, tgt32}, tgt_exp32(p, {32'd0, e32}));
        chk({tag, ".err32"}, {63'd0, err32}, {63'd0, eerr});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; inst = '0; pc = '0;
        @(negedge clk);
        step();
        step();
        chk("rst.vld", {63'd0, vld64}, 64'd0);
        chk("rst.rdy", {63'd0, rdy64}, 64'd0);
        chk("rst.imm", imm64, 64'd0);
        chk("rst.tgt", tgt64, 64'd0);
        chk("rst.err", {63'd0, err64}, 64'd0);
        chk("rst.rdy32", {63'd0, rdy32}, 64'd0);
        chk("rst.vld32", {63'd0, vld32}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst.rdy_after", {63'd0, rdy64}, 64'd1);
        @(negedge clk);

        vec("I.neg1", 6'b000001, 32'hFFF00093, 64'h0,            64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        vec("B.m4",   6'b000100, 32'hFE000EE3, 64'h8000_0000,    64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        vec("U.neg",  6'b001000, 32'h800000B7, 64'h1000,         64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
        vec("S.p12",  6'b000010, 32'h00112623, 64'h200,          64'd12,                  32'd12,        1'b0);
        vec("J.p4",   6'b010000, 32'h0040006F, 64'h10,           64'd4,                   32'd4,         1'b0);
        vec("J.m4",   6'b010000, 32'hFFDFF06F, 64'h0,            64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        vec("Z.31",   6'b100000, 32'hFFFF8073, 64'h4,            64'd31,                  32'd31,        1'b0);
        vec("sel0",   6'b000000, 32'hFFFFFFFF, 64'h8,            64'd0,                   32'd0,         1'b0);
        vec("selx",   6'b000011, 32'hFFFFFFFF, 64'hC,            64'd0,                   32'd0,         1'b1);

        // Backpressure: two accepted, third stalls until skid drains.
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("drain.vld", {63'd0, vld64}, 64'd0);
        out_ready = 1'b0; sel = 6'b000001; pc = '0;
        inst = 32'h00100093; in_valid = 1'b1;
        step();
        chk("bp.a.rdy", {63'd0, rdy64}, 64'd1);
        chk("bp.a.imm", imm64, 64'd1);
        inst = 32'h00200093;
        step();
        chk("bp.b.rdy", {63'd0, rdy64}, 64'd0);
        chk("bp.b.imm", imm64, 64'd1);
        inst = 32'h00300093;
        step();
        chk("bp.c.rdy", {63'd0, rdy64}, 64'd0);
        chk("bp.c.hold", imm64, 64'd1);
        chk("bp.c.vld", {63'd0, vld64}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp.d1.imm", imm64, 64'd2);
        chk("bp.d1.rdy", {63'd0, rdy64}, 64'd1);
        step();
        chk("bp.d2.imm", imm64, 64'd3);
        chk("bp.d2.vld", {63'd0, vld64}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp.empty", {63'd0, vld64}, 64'd0);

        // Flush with both entries full and a valid input pending.
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500093;
        step();
        step();
        chk("fl.full", {63'd0, rdy64}, 64'd0);
        flush = 1'b1;
        step();
        chk("fl.vld", {63'd0, vld64}, 64'd0);
        chk("fl.rdy", {63'd0, rdy64}, 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl.none", {63'd0, vld64}, 64'd0);

        // Reset mid-operation, asserted alongside flush.
        in_valid = 1'b1; inst = 32'h00700093;
        step();
        chk("rm.pre", {63'd0, vld64}, 64'd1);
        rst = 1'b1; flush = 1'b1;
        step();
        chk("rm.vld", {63'd0, vld64}, 64'd0);
        chk("rm.imm", imm64, 64'd0);
        chk("rm.rdy", {63'd0, rdy64}, 64'd0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        chk("rm.idle", {63'd0, vld64}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
